// File: rtl/pio_pkg.sv
// Shared constants and types for the Avalon-MM parallel I/O controller.
// Register offsets, bus width and edge-detect mode encoding.
package pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_DIR      = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK = 3'd2;
    localparam logic [2:0] REG_EDGE_CAP = 3'd3;
    localparam logic [2:0] REG_OUT_SET  = 3'd4;
    localparam logic [2:0] REG_OUT_CLR  = 3'd5;

    typedef enum logic [1:0] {
        RISING  = 2'd0,
        FALLING = 2'd1,
        BOTH    = 2'd2
    } edge_mode_t;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus one-cycle history for edge detection.
// edge_pulse is combinational from registered state only.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam edge_mode_t MODE = edge_mode_t'(EDGE_MODE);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            hist  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_q = chain[SYNC_STAGES-1];

    always_comb begin
        edge_pulse = '0;
        case (MODE)
            RISING:  edge_pulse = sync_q & ~hist;
            FALLING: edge_pulse = ~sync_q & hist;
            BOTH:    edge_pulse = sync_q ^ hist;
            default: edge_pulse = '0;
        endcase
    end

endmodule

// File: rtl/avmm_pio_ctrl.sv
// Avalon-MM PIO: data/direction registers, atomic set/clear,
// edge capture with write-1-to-clear and a maskable level irq.
module avmm_pio_ctrl
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_MODE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_val;
    logic             wr_data, wr_dir, wr_mask, wr_set, wr_clr;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .din        (pio_in),
        .sync_q     (sync_in),
        .edge_pulse (edge_pulse)
    );

    assign wdata   = WIDTH'(avs_writedata);
    assign wr_data = avs_write && (avs_address == REG_DATA);
    assign wr_dir  = avs_write && (avs_address == REG_DIR);
    assign wr_mask = avs_write && (avs_address == REG_IRQ_MASK);
    assign wr_set  = avs_write && (avs_address == REG_OUT_SET);
    assign wr_clr  = avs_write && (avs_address == REG_OUT_CLR);
    assign cap_clr = (avs_write && (avs_address == REG_EDGE_CAP)) ? wdata : '0;

    // Reads see the registered (pre-write) state of this cycle.
    always_comb begin
        rd_val = '0;
        case (avs_address)
            REG_DATA:     rd_val = (pio_out & pio_oe) | (sync_in & ~pio_oe);
            REG_DIR:      rd_val = pio_oe;
            REG_IRQ_MASK: rd_val = irq_mask;
            REG_EDGE_CAP: rd_val = edge_cap;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pio_out           <= OUT_RESET;
            pio_oe            <= DIR_RESET;
            irq_mask          <= '0;
            edge_cap          <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            unique case (1'b1)
                wr_data: pio_out  <= wdata;
                wr_set:  pio_out  <= pio_out | wdata;
                wr_clr:  pio_out  <= pio_out & ~wdata;
                wr_dir:  pio_oe   <= wdata;
                wr_mask: irq_mask <= wdata;
                default: ;
            endcase
            // A fresh edge outranks a clear of the same bit.
            edge_cap          <= (edge_cap & ~cap_clr) | edge_pulse;
            irq               <= |(edge_cap & irq_mask);
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= BUS_W'(rd_val);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        assert (WIDTH >= 1 && WIDTH <= 32);
        assert (SYNC_STAGES >= 2 && SYNC_STAGES <= 4);
        assert (EDGE_MODE >= 0 && EDGE_MODE <= 2);
    end

endmodule

// File: tb/tb_avmm_pio_ctrl.sv
// Self-checking bench for avmm_pio_ctrl (WIDTH=8, rising edge, 2 sync stages).
// Read expectations are queued at issue and compared when readdatavalid fires.
module tb_avmm_pio_ctrl;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [7:0]  pio_in;
    logic [7:0]  pio_out;
    logic [7:0]  pio_oe;
    logic        irq;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    avmm_pio_ctrl #(
        .WIDTH       (8),
        .OUT_RESET   (8'h5A),
        .DIR_RESET   (8'hFF),
        .EDGE_MODE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .pio_in            (pio_in),
        .pio_out           (pio_out),
        .pio_oe            (pio_oe),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (avs_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) check("rdv_spurious", 32'd1, 32'd0);
            else check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] e,
                            input string t);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rst_exp[8];
        rst_exp = '{32'h5A, 32'hFF, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0; avs_address = '0; avs_read = 1'b0;
        avs_write = 1'b0; avs_writedata = '0; pio_in = '0;
        repeat (3) @(negedge clk);
        check("rst_out", pio_out, 32'h5A);
        check("rst_oe", pio_oe, 32'hFF);
        check("rst_irq", irq, 0);
        check("rst_rdv", avs_readdatavalid, 0);
        check("rst_rdata", avs_readdata, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) bus_read(3'(i), rst_exp[i], $sformatf("rst_reg%0d", i));

        bus_write(REG_DATA, 32'hF0);
        check("wr_data_pin", pio_out, 32'hF0);
        bus_write(REG_OUT_SET, 32'h03);
        check("set_pin", pio_out, 32'hF3);
        bus_write(REG_OUT_CLR, 32'h80);
        check("clr_pin", pio_out, 32'h73);
        bus_read(REG_DATA, 32'h73, "data_setclr");
        bus_read(REG_OUT_SET, 32'h0, "set_reads0");
        bus_write(REG_DATA, 32'hFFFFFF00);
        check("wide_wr_pin", pio_out, 32'h00);

        bus_write(REG_DIR, 32'h0F);
        check("dir_pin", pio_oe, 32'h0F);
        bus_write(REG_DATA, 32'hAA);
        @(negedge clk) pio_in = 8'h3C;
        @(negedge clk);
        bus_read(REG_DATA, 32'h3A, "data_mixed");
        bus_read(REG_EDGE_CAP, 32'h3C, "cap_rise_multi");
        check("irq_masked", irq, 0);
        bus_write(REG_EDGE_CAP, 32'hFF);
        @(negedge clk) pio_in = 8'h00;
        repeat (5) @(negedge clk);
        bus_read(REG_EDGE_CAP, 32'h0, "cap_fall_ignored");

        bus_write(REG_IRQ_MASK, 32'h01);
        @(negedge clk) pio_in = 8'h01;
        repeat (3) @(posedge clk);
        #1 check("irq_not_yet", irq, 0);
        @(posedge clk);
        #1 check("irq_assert", irq, 1);
        bus_read(REG_EDGE_CAP, 32'h01, "cap_bit0");
        bus_read(REG_DATA, 32'h0A, "data_in_bit0");
        bus_write(REG_EDGE_CAP, 32'h01);
        @(posedge clk);
        #1 check("irq_cleared", irq, 0);

        @(negedge clk) pio_in = 8'h00;
        repeat (4) @(negedge clk);
        pio_in = 8'h01;
        repeat (5) @(negedge clk);
        check("irq_rearm", irq, 1);
        pio_in = 8'h00;
        repeat (4) @(negedge clk);
        check("irq_hold", irq, 1);
        pio_in = 8'h01;
        @(negedge clk);
        bus_write(REG_EDGE_CAP, 32'h01);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("irq_edge_wins", irq, 1);
        end
        bus_read(REG_EDGE_CAP, 32'h01, "cap_edge_wins");

        @(negedge clk);
        avs_address = REG_DIR; avs_writedata = 32'h55;
        avs_read = 1'b1; avs_write = 1'b1;
        exp_q.push_back(32'h0F); tag_q.push_back("rw_old_dir");
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        check("rw_dir_pin", pio_oe, 32'h55);
        bus_read(REG_DIR, 32'h55, "rw_new_dir");

        @(negedge clk);
        avs_address = REG_DATA; avs_read = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 check("mid_rst_rdv", avs_readdatavalid, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_out", pio_out, 32'h5A);
        check("mid_rst_oe", pio_oe, 32'hFF);
        @(negedge clk) avs_read = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("post_rst_rdv", avs_readdatavalid, 0);
        bus_read(REG_EDGE_CAP, 32'h00, "cap_post_rst_early");
        bus_read(REG_DIR, 32'hFF, "dir_post_rst");
        bus_read(REG_IRQ_MASK, 32'h00, "mask_post_rst");
        bus_read(REG_DATA, 32'h5A, "data_post_rst");
        bus_read(REG_EDGE_CAP, 32'h01, "cap_post_rst_high");
        check("irq_post_rst", irq, 0);

        repeat (3) @(negedge clk);
        check("q_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
